seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned restoring divider, the inverse of the combinational 8x8 `multiplier`. Given a 16-bit dividend `z` and an 8-bit divisor `b`, it returns a 16-bit quotient and an 8-bit remainder. It resolves one quotient bit per clock using a start/busy/done handshake. It sits beside `multiplier` in the arithmetic datapath, and round-trip checks (`z = a*b` → `q = a`, `r = 0`) use it.

## Interface
- No parameters; widths are fixed (dividend 16, divisor 8, quotient 16, remainder 8).
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a division; sampled only in IDLE
- `z`  in  16  dividend, captured on accepted `start`
- `b`  in  8  divisor, captured on accepted `start`
- `busy`  out  1  high while an operation is in progress (RUN or DONE)
- `done`  out  1  one-cycle pulse; `q`, `r` and `dbz` are valid
- `q`  out  16  quotient
- `r`  out  8  remainder
- `dbz`  out  1  divide-by-zero flag for the last result

## Operation
- Reset (`rst`=1 at a rising edge):
  - state ← IDLE.
  - `busy`=0, `done`=0, `q`=16'h0000, `r`=8'h00, `dbz`=0.
  - Internal counter and operand registers are cleared.
- IDLE:
  - `start`=1 captures `z` and `b`, and clears the partial remainder, counter and `dbz`.
  - If `b`≠0, go to RUN. If `b`==0, go to DONE with `q`=16'hFFFF, `r`=8'h00, `dbz`=1.
- RUN, one iteration per cycle, counter 0..15, dividend bits consumed MSB first:
  - Form a 9-bit trial value `t = {rem, dividend[15]}`. Shift the dividend register left by one.
  - If `t ≥ {1'b0, b}`: `rem ← t − b` and shift quotient bit 1 into the LSB. Otherwise `rem ← t[7:0]` and shift in 0.
  - The 9-bit compare is mandatory. `rem` ≤ `b`−1 ≤ 254, so `t` can reach 509; an 8-bit compare is wrong.
  - After the counter-15 iteration, go to DONE.
- DONE:
  - `q` ← final quotient, `r` ← final remainder, `done`=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- `start` outside IDLE is ignored: no capture, no effect on the running operation.
- Changes on `z` or `b` after capture do not affect the result.
- Result holding: `q`, `r` and `dbz` keep the last result until the next accepted `start` or reset. Intermediate values are never visible on `q` or `r`.
- Results satisfy `z == q*b + r` and `r < b` for every `b`≠0.

## Timing
- Accepted `start` is sampled at edge N (state IDLE).
- Normal case (`b`≠0):
  - RUN occupies cycles N+1..N+16 (16 iterations).
  - DONE is cycle N+17: `done`=1, `q`/`r` valid.
  - `busy`=1 from N+1 through N+17, and 0 from N+18.
  - Total latency is 17 cycles from the accepting edge to `done`.
- Divide by zero: DONE at N+1 (`done`=1, `busy`=1), IDLE at N+2. Latency is 1 cycle.
- Earliest next accepted `start`: the edge ending cycle N+18 (normal) or N+2 (divide by zero). There is no overlap or back-to-back acceptance in DONE.
- Reset mid-operation: any state returns to IDLE at the next edge with all outputs at reset values. No `done` pulse is emitted for the aborted operation.
- Reset has priority over `start` asserted at the same edge.
- `done` and `busy` come directly from registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then `z`=420, `b`=21, one-cycle `start` → `done` exactly 17 cycles later with `q`=20, `r`=0, `dbz`=0. `busy` is high for 17 cycles.
- Round-trip vectors applied sequentially:
  - 4410/21 → `q`=210, `r`=0
  - 3864/92 → `q`=42, `r`=0
  - 8/2 → `q`=4, `r`=0
  - 0/5 → `q`=0, `r`=0
- Width edges:
  - 65535/1 → `q`=65535, `r`=0
  - 65535/255 → `q`=257, `r`=0
  - 1000/7 → `q`=142, `r`=6
  - 65534/255 → `q`=256, `r`=254 (exercises the 9-bit compare)
- Divide by zero: `z`=1234, `b`=0 → `done` 1 cycle after accept with `q`=16'hFFFF, `r`=0, `dbz`=1. The next normal op (1000/7) clears `dbz` and returns `q`=142, `r`=6.
- `start` held high continuously, with `z`/`b` changed mid-run → only the IDLE-sampled operands are used. Starts are accepted every 18 cycles, and `done` pulses exactly once per operation.
- Assert `rst` at cycle N+8 of a 1000/7 run → `busy`, `done`, `q`, `r` and `dbz` are all 0 on the next cycle. No `done` appears afterwards, and a fresh 420/21 then returns `q`=20, `r`=0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] z,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [8:0]  trial;
  logic [8:0]  diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    // Trial value needs 9 bits: rem can be up to 254, so {rem, bit} reaches 509.
    trial   = {rem_q, dvd_q[15]};
    diff    = trial - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = z;
          dvs_d = b;
          rem_d = 8'h00;
          cnt_d = 4'd0;
          quo_d = 16'h0000;
          dbz_d = 1'b0;
          if (b == 8'h00) begin
            state_d = DONE;
            q_d     = 16'hFFFF;
            r_d     = 8'h00;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[14:0], 1'b0};
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = diff[7:0];
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = trial[7:0];
          quo_d = {quo_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        // Publish only the finished result so q/r never show partial values.
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          q_d     = quo_d;
          r_d     = rem_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dvd_q   <= 16'h0000;
      dvs_q   <= 8'h00;
      rem_q   <= 8'h00;
      quo_q   <= 16'h0000;
      q_q     <= 16'h0000;
      r_q     <= 8'h00;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors plus random operands
// compared against plain integer division.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] z;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;

  int tests;
  int fails;

  seq_divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .z    (z),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic, with the divide-by-zero convention.
  function automatic logic [40:0] ref_div(input logic [15:0] zz, input logic [7:0] bb);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          el;
    if (bb == 0) begin
      eq = 16'hFFFF; er = 8'h00; ed = 1'b1; el = 1;
    end else begin
      eq = 16'(int'(zz) / int'(bb));
      er = 8'(int'(zz) % int'(bb));
      ed = 1'b0; el = 17;
    end
    return {eq, er, ed, 16'(el)};
  endfunction

  // Issues one start and waits (bounded) for done; returns observations.
  task automatic do_op(input logic [15:0] zz, input logic [7:0] bb,
                       output int lat, output int bc, output logic to,
                       output logic [15:0] oq, output logic [7:0] orr, output logic od);
    @(negedge clk);
    z = zz; b = bb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    z = 16'($urandom); b = 8'($urandom);
    lat = 0; bc = 0; to = 1'b1; oq = 'x; orr = 'x; od = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (busy) bc++;
      if (done) begin
        lat = k; oq = q; orr = r; od = dbz; to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; z = 16'h0; b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, q, r, dbz} !== 27'h0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, need all zero",
               busy, done, q, r, dbz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc; logic to; logic [15:0] oq; logic [7:0] orr; logic od;
    do_op(16'd420, 8'd21, lat, bc, to, oq, orr, od);
    tests++;
    if (to || lat != 17 || bc != 17) begin
      fails++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d timeout=%b, need 17/17/0", lat, bc, to);
    end
    tests++;
    if ({oq, orr, od} !== {16'd20, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, need q=20 r=0 dbz=0", oq, orr, od);
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_after: got busy=%b done=%b, need 0/0", busy, done);
    end
    tests++;
    if (q !== 16'd20 || r !== 8'd0) begin
      fails++;
      $display("FAIL basic_hold: got q=%0d r=%0d, need result held q=20 r=0", q, r);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] vz [10] = '{16'd4410, 16'd3864, 16'd8, 16'd0, 16'd65535,
                             16'd65535, 16'd1000, 16'd65534, 16'd1234, 16'd1000};
    logic [7:0]  vb [10] = '{8'd21, 8'd92, 8'd2, 8'd5, 8'd1,
                             8'd255, 8'd7, 8'd255, 8'd0, 8'd7};
    int lat, bc; logic to; logic [15:0] oq; logic [7:0] orr; logic od;
    logic [40:0] e;
    for (int i = 0; i < 10; i++) begin
      e = ref_div(vz[i], vb[i]);
      do_op(vz[i], vb[i], lat, bc, to, oq, orr, od);
      tests++;
      if (to || lat != int'(e[15:0]) || {oq, orr, od} !== e[40:16]) begin
        fails++;
        $display("FAIL vector_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d, need q=%0d r=%0d dbz=%b lat=%0d",
                 i, vz[i], vb[i], oq, orr, od, lat, e[40:25], e[24:17], e[16], e[15:0]);
      end else begin
        $display("[TB] vector %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", vz[i], vb[i], oq, orr, od, lat);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oz [3] = '{16'd4410, 16'd65534, 16'd1000};
    logic [7:0]  ob [3] = '{8'd21, 8'd255, 8'd7};
    int ndone; int at [3]; logic [15:0] gq [3]; logic [7:0] gr [3];
    logic [40:0] e;
    ndone = 0;
    @(negedge clk);
    z = oz[0]; b = ob[0]; start = 1'b1;
    for (int c = 1; c <= 53; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (ndone < 3) begin at[ndone] = c; gq[ndone] = q; gr[ndone] = r; end
        ndone++;
      end
      @(negedge clk);
      if (c == 53) start = 1'b0;
      else if (c % 18 == 0) begin z = oz[c / 18]; b = ob[c / 18]; end
      else begin z = 16'($urandom); b = 8'($urandom); end
    end
    tests++;
    if (ndone != 3) begin
      fails++;
      $display("FAIL held_start_count: got %0d done pulses, need 3", ndone);
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = ref_div(oz[i], ob[i]);
        tests++;
        if (at[i] != 17 + 18 * i || gq[i] !== e[40:25] || gr[i] !== e[24:17]) begin
          fails++;
          $display("FAIL held_start_op%0d: got cycle=%0d q=%0d r=%0d, need cycle=%0d q=%0d r=%0d",
                   i, at[i], gq[i], gr[i], 17 + 18 * i, e[40:25], e[24:17]);
        end
      end
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic to; logic [15:0] oq; logic [7:0] orr; logic od;
    int nd;
    @(negedge clk);
    z = 16'd1000; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, q, r, dbz} !== 27'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, need all zero",
               busy, done, q, r, dbz);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    tests++;
    if (nd != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: got %0d cycles with done/busy after abort, need 0", nd);
    end
    do_op(16'd420, 8'd21, lat, bc, to, oq, orr, od);
    tests++;
    if (to || lat != 17 || {oq, orr, od} !== {16'd20, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_recover: got q=%0d r=%0d dbz=%b lat=%0d, need q=20 r=0 dbz=0 lat=17",
               oq, orr, od, lat);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int lat, bc; logic to; logic [15:0] oq; logic [7:0] orr; logic od;
    logic [15:0] rz; logic [7:0] rb; logic [40:0] e;
    for (int i = 0; i < 25; i++) begin
      rz = 16'($urandom);
      rb = (i % 8 == 3) ? 8'd0 : ((i % 4 == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom));
      e = ref_div(rz, rb);
      do_op(rz, rb, lat, bc, to, oq, orr, od);
      tests++;
      if (to || lat != int'(e[15:0]) || {oq, orr, od} !== e[40:16]) begin
        fails++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d, need q=%0d r=%0d dbz=%b lat=%0d",
                 i, rz, rb, oq, orr, od, lat, e[40:25], e[24:17], e[16], e[15:0]);
      end else begin
        $display("[TB] random %0d/%0d -> q=%0d r=%0d dbz=%b", rz, rb, oq, orr, od);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
